// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter.
// Optional fixed-priority build: PIO_ARB_FIXED_PRIO_EN (see pio_rr_arbiter).
package pio_arb_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 2;

  localparam int unsigned REQ_HPS  = 0;
  localparam int unsigned REQ_FPGA = 1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } arb_state_e;

endpackage

// File: rtl/pio_rr_arbiter.sv
// Two-way grant logic: request vector plus last winner in, one-hot grant out.
// Define PIO_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module pio_rr_arbiter
  import pio_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

`ifdef PIO_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    gnt_o           = 2'b00;
    gnt_o[REQ_HPS]  = req_i[REQ_HPS];
    gnt_o[REQ_FPGA] = req_i[REQ_FPGA] & ~req_i[REQ_HPS];
  end
`else
  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: whoever did not win last time goes first.
      2'b11:   gnt_o = last_grant_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
`endif

endmodule

// File: rtl/pio_access_arbiter.sv
// Serialises two Avalon-MM requesters onto one zero-latency PIO register slave.
// Define PIO_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_waitrequest,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_waitrequest,

  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata,

  output logic              grant
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              cs_q, cs_d;
  logic              write_n_q, write_n_d;
  logic [1:0]        wait_q, wait_d;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              win;
  logic              last_grant;

  assign req[REQ_HPS]  = m0_read | m0_write;
  assign req[REQ_FPGA] = m1_read | m1_write;

  pio_rr_arbiter u_arb (
    .req_i        (req),
    .last_grant_i (last_grant),
    .gnt_o        (gnt)
  );

  assign win = gnt[REQ_FPGA];

`ifdef PIO_ARB_FIXED_PRIO_EN
  assign last_grant = 1'b1;
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == StIdle && |req) begin
      last_grant_d = win;
    end
  end

  // Reset to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant = last_grant_q;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    wait_d    = 2'b11;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d   = StAccess;
          grant_d   = win;
          addr_d    = win ? m1_address   : m0_address;
          wr_d      = win ? m1_write     : m0_write;
          wdata_d   = win ? m1_writedata : m0_writedata;
          cs_d      = 1'b1;
          write_n_d = ~(win ? m1_write : m0_write);
        end
      end
      StAccess: begin
        if (!wr_q) begin
          rbuf_d = s_readdata;
        end
        wait_d[grant_q] = 1'b0;
        state_d         = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      wait_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      wait_q    <= wait_d;
    end
  end

  assign s_address      = addr_q;
  assign s_chipselect   = cs_q;
  assign s_write_n      = write_n_q;
  assign s_writedata    = wdata_q;
  assign m0_readdata    = rbuf_q;
  assign m1_readdata    = rbuf_q;
  assign m0_waitrequest = wait_q[REQ_HPS];
  assign m1_waitrequest = wait_q[REQ_FPGA];
  assign grant          = grant_q;

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Directed bench for pio_access_arbiter with a one-register PIO slave model at address 0.
// Grant expectations follow PIO_ARB_FIXED_PRIO_EN when it is defined.
module tb_pio_access_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [1:0]  s_address;
  logic        s_chipselect, s_write_n;
  logic [31:0] s_writedata, s_readdata;
  logic        grant;

  logic [31:0] pio_q;
  int          n_checks;
  int          n_bad;

  pio_access_arbiter #(
    .DATA_W (32),
    .ADDR_W (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_chipselect   (s_chipselect),
    .s_write_n      (s_write_n),
    .s_writedata    (s_writedata),
    .s_readdata     (s_readdata),
    .grant          (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PIO slave: one data register at address 0, other addresses read zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_q <= 32'h0;
    end else if (s_chipselect && !s_write_n && s_address == 2'd0) begin
      pio_q <= s_writedata;
    end
  end
  assign s_readdata = (s_address == 2'd0) ? pio_q : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_address = 2'd0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0;
    m1_address = 2'd0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic exp_gnt [4];

  initial begin
    n_checks = 0;
    n_bad    = 0;
    idle_inputs();
    do_reset();

    // Reset state
    check("rst_wait0", {31'h0, m0_waitrequest}, 32'h1);
    check("rst_wait1", {31'h0, m1_waitrequest}, 32'h1);
    check("rst_cs", {31'h0, s_chipselect}, 32'h0);
    check("rst_wn", {31'h0, s_write_n}, 32'h1);
    check("rst_addr", {30'h0, s_address}, 32'h0);
    check("rst_wdata", s_writedata, 32'h0);
    check("rst_rdata0", m0_readdata, 32'h0);
    check("rst_rdata1", m1_readdata, 32'h0);
    check("rst_grant", {31'h0, grant}, 32'h0);

    // Single write from m0
    m0_write = 1'b1; m0_address = 2'd0; m0_writedata = 32'hDEADBEEF;
    tick();
    check("wr_acc_cs", {31'h0, s_chipselect}, 32'h1);
    check("wr_acc_wn", {31'h0, s_write_n}, 32'h0);
    check("wr_acc_wdata", s_writedata, 32'hDEADBEEF);
    check("wr_acc_wait0", {31'h0, m0_waitrequest}, 32'h1);
    check("wr_acc_grant", {31'h0, grant}, 32'h0);
    tick();
    check("wr_done_cs", {31'h0, s_chipselect}, 32'h0);
    check("wr_done_wn", {31'h0, s_write_n}, 32'h1);
    check("wr_done_wait0", {31'h0, m0_waitrequest}, 32'h0);
    check("wr_done_wait1", {31'h0, m1_waitrequest}, 32'h1);
    check("wr_pio", pio_q, 32'hDEADBEEF);
    m0_write = 1'b0;
    tick();
    check("wr_idle_wait0", {31'h0, m0_waitrequest}, 32'h1);
    check("wr_idle_cs", {31'h0, s_chipselect}, 32'h0);

    // Read-back from m1, address 0 then 1
    m1_read = 1'b1; m1_address = 2'd0;
    tick();
    check("rd0_acc_cs", {31'h0, s_chipselect}, 32'h1);
    check("rd0_acc_wn", {31'h0, s_write_n}, 32'h1);
    check("rd0_acc_grant", {31'h0, grant}, 32'h1);
    tick();
    check("rd0_done_wait1", {31'h0, m1_waitrequest}, 32'h0);
    check("rd0_done_wait0", {31'h0, m0_waitrequest}, 32'h1);
    check("rd0_data", m1_readdata, 32'hDEADBEEF);
    m1_address = 2'd1;
    tick();
    tick();
    check("rd1_acc_addr", {30'h0, s_address}, 32'h1);
    tick();
    check("rd1_done_wait1", {31'h0, m1_waitrequest}, 32'h0);
    check("rd1_data", m1_readdata, 32'h0);
    m1_read = 1'b0;
    tick();

    // Read and write both high: treated as a write
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 2'd0; m0_writedata = 32'h55;
    tick();
    check("rw_acc_wn", {31'h0, s_write_n}, 32'h0);
    tick();
    check("rw_pio", pio_q, 32'h55);
    idle_inputs();
    tick();

    // Request dropped during ACCESS still completes exactly once
    m0_write = 1'b1; m0_address = 2'd0; m0_writedata = 32'h1234;
    tick();
    check("drop_acc_cs", {31'h0, s_chipselect}, 32'h1);
    m0_write = 1'b0;
    tick();
    check("drop_done_wait0", {31'h0, m0_waitrequest}, 32'h0);
    check("drop_pio", pio_q, 32'h1234);
    tick();
    check("drop_idle_wait0", {31'h0, m0_waitrequest}, 32'h1);
    tick();
    check("drop_no_retry_cs", {31'h0, s_chipselect}, 32'h0);
    check("drop_no_retry_wait0", {31'h0, m0_waitrequest}, 32'h1);

    // Continuous contention from reset
    reset_n = 1'b0;
    m0_write = 1'b1; m0_writedata = 32'h1; m0_address = 2'd0;
    m1_write = 1'b1; m1_writedata = 32'h2; m1_address = 2'd0;
    tick();
    reset_n = 1'b1;
`ifdef PIO_ARB_FIXED_PRIO_EN
    exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("cont_grant%0d", i), {31'h0, grant}, {31'h0, exp_gnt[i]});
      check($sformatf("cont_cs%0d", i), {31'h0, s_chipselect}, 32'h1);
      tick();
      check($sformatf("cont_wait0_%0d", i), {31'h0, m0_waitrequest}, {31'h0, exp_gnt[i]});
      check($sformatf("cont_wait1_%0d", i), {31'h0, m1_waitrequest}, {31'h0, ~exp_gnt[i]});
      check($sformatf("cont_pio%0d", i), pio_q, exp_gnt[i] ? 32'h2 : 32'h1);
      tick();
    end
    idle_inputs();
    tick();

    // Reset in the middle of ACCESS aborts the transfer
    m0_write = 1'b1; m0_address = 2'd0; m0_writedata = 32'hAAAA5555;
    tick();
    check("abort_acc_cs", {31'h0, s_chipselect}, 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_cs", {31'h0, s_chipselect}, 32'h0);
    check("abort_wn", {31'h0, s_write_n}, 32'h1);
    check("abort_addr_wdata", s_writedata, 32'h0);
    check("abort_wait0", {31'h0, m0_waitrequest}, 32'h1);
    check("abort_rdata", m0_readdata, 32'h0);
    check("abort_pio", pio_q, 32'h0);
    m0_write = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_nodone_wait0_%0d", i), {31'h0, m0_waitrequest}, 32'h1);
      check($sformatf("abort_nodone_cs%0d", i), {31'h0, s_chipselect}, 32'h0);
    end
    check("abort_pio_after", pio_q, 32'h0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
